// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle control FSM:
// state codes, ISA opcodes/funcs, ALU ops and datapath select codes.
package multicycle_control_pkg;

  localparam int OPW   = 4;
  localparam int FUNCW = 6;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R,
    C_ALU_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_JUMPREG,
    C_WWD,
    C_HLT,
    C_ILLEGAL
  } iclass_t;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_ORR   = 4'd3;
  localparam logic [3:0] ALU_NOT   = 4'd4;
  localparam logic [3:0] ALU_TCP   = 4'd5;
  localparam logic [3:0] ALU_SHL   = 4'd6;
  localparam logic [3:0] ALU_SHR   = 4'd7;
  localparam logic [3:0] ALU_LHI   = 4'd8;
  localparam logic [3:0] ALU_PASSA = 4'd9;

  localparam logic [1:0] SRCA_REG = 2'd0;
  localparam logic [1:0] SRCA_PC  = 2'd1;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC1 = 2'd2;

  localparam logic [1:0] RD_RD   = 2'd0;
  localparam logic [1:0] RD_RT   = 2'd1;
  localparam logic [1:0] RD_LINK = 2'd2;

  localparam logic MD_PC  = 1'b0;
  localparam logic MD_ALU = 1'b1;

  localparam logic JD_TGT = 1'b0;
  localparam logic JD_REG = 1'b1;

endpackage

// File: rtl/multicycle_control_decode.sv
// Instruction classifier: opcode/func -> class,
// link flag and execute-stage ALU operation.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [OPW-1:0]   i_opcode,
  input  logic [FUNCW-1:0] i_func,
  output iclass_t          o_cls,
  output logic             o_link,
  output logic [3:0]       o_alu_op
);

  always_comb begin
    o_cls    = C_ILLEGAL;
    o_link   = 1'b0;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        o_cls    = C_BRANCH;
        o_alu_op = ALU_SUB;
      end
      OP_ADI: o_cls = C_ALU_I;
      OP_ORI: begin
        o_cls    = C_ALU_I;
        o_alu_op = ALU_ORR;
      end
      OP_LHI: begin
        o_cls    = C_ALU_I;
        o_alu_op = ALU_LHI;
      end
      OP_LWD: o_cls = C_LOAD;
      OP_SWD: o_cls = C_STORE;
      OP_JMP: o_cls = C_JUMP;
      OP_JAL: begin
        o_cls  = C_JUMP;
        o_link = 1'b1;
      end
      OP_RTYPE: begin
        case (i_func)
          FN_ADD: o_cls = C_ALU_R;
          FN_SUB: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_SUB;
          end
          FN_AND: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_AND;
          end
          FN_ORR: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_ORR;
          end
          FN_NOT: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_NOT;
          end
          FN_TCP: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_TCP;
          end
          FN_SHL: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_SHL;
          end
          FN_SHR: begin
            o_cls    = C_ALU_R;
            o_alu_op = ALU_SHR;
          end
          FN_JPR: begin
            o_cls    = C_JUMPREG;
            o_alu_op = ALU_PASSA;
          end
          FN_JRL: begin
            o_cls    = C_JUMPREG;
            o_link   = 1'b1;
            o_alu_op = ALU_PASSA;
          end
          FN_WWD: begin
            o_cls    = C_WWD;
            o_alu_op = ALU_PASSA;
          end
          FN_HLT:  o_cls = C_HLT;
          default: o_cls = C_ILLEGAL;
        endcase
      end
      default: o_cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: IF/ID/EX/MEM/WB microsteps, memory-ready
// stalls, one retire strobe per instruction, HALT parking.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW_P   = OPW,
  parameter int FUNCW_P = FUNCW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OPW_P-1:0]   opcode,
  input  logic [FUNCW_P-1:0] func_code,
  input  logic               mem_ready,
  output logic               PVSWriteEn,
  output logic               jump,
  output logic               branch,
  output logic               WWD,
  output logic               HLT,
  output logic [1:0]         MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               MemDest,
  output logic [1:0]         RegDest,
  output logic               JumpDest,
  output logic [1:0]         Bcond,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic               carry
);

  state_t     r_state;
  state_t     w_next;
  iclass_t    w_cls;
  logic       w_link;
  logic [3:0] w_alu_op;
  logic       w_rtype;

  control_decode u_dec (
    .i_opcode (opcode),
    .i_func   (func_code),
    .o_cls    (w_cls),
    .o_link   (w_link),
    .o_alu_op (w_alu_op)
  );

  assign w_rtype = (opcode == OP_RTYPE);
  assign carry   = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IF;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = S_IF;
    PVSWriteEn = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    WWD        = 1'b0;
    HLT        = 1'b0;
    MemToReg   = M2R_ALU;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    MemDest    = MD_PC;
    RegDest    = RD_RD;
    JumpDest   = JD_TGT;
    Bcond      = opcode[1:0] & {2{1'b0}};
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALU_ADD;
    case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        MemDest = MD_PC;
        w_next  = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_ONE;
        ALUOp   = ALU_ADD;
        w_next  = S_EX;
        unique case (1'b1)
          (w_cls == C_JUMP): begin
            jump       = 1'b1;
            JumpDest   = JD_TGT;
            PVSWriteEn = 1'b1;
            RegWrite   = w_link;
            RegDest    = w_link ? RD_LINK : RD_RD;
            MemToReg   = w_link ? M2R_PC1 : M2R_ALU;
            w_next     = S_IF;
          end
          (w_cls == C_HLT): w_next = S_HALT;
          (w_cls == C_ILLEGAL): begin
            PVSWriteEn = 1'b1;
            w_next     = S_IF;
          end
          default: w_next = S_EX;
        endcase
      end
      S_EX: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = w_rtype ? SRCB_REG : SRCB_IMM;
        ALUOp   = w_alu_op;
        w_next  = S_IF;
        case (w_cls)
          C_BRANCH: begin
            branch     = 1'b1;
            Bcond      = opcode[1:0];
            PVSWriteEn = 1'b1;
          end
          C_JUMPREG: begin
            jump       = 1'b1;
            JumpDest   = JD_REG;
            PVSWriteEn = 1'b1;
            RegWrite   = w_link;
            RegDest    = w_link ? RD_LINK : RD_RD;
            MemToReg   = w_link ? M2R_PC1 : M2R_ALU;
          end
          C_WWD: begin
            WWD        = 1'b1;
            PVSWriteEn = 1'b1;
          end
          C_LOAD, C_STORE:  w_next = S_MEM;
          C_ALU_R, C_ALU_I: w_next = S_WB;
          // opcode changed under us: retire as a NOP rather than wedge
          default: PVSWriteEn = 1'b1;
        endcase
      end
      S_MEM: begin
        MemDest  = MD_ALU;
        MemRead  = (w_cls == C_LOAD);
        MemWrite = (w_cls == C_STORE);
        if (!mem_ready) begin
          w_next = S_MEM;
        end else if (w_cls == C_STORE) begin
          PVSWriteEn = 1'b1;
          w_next     = S_IF;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        PVSWriteEn = 1'b1;
        MemToReg   = (w_cls == C_LOAD) ? M2R_MEM : M2R_ALU;
        RegDest    = w_rtype ? RD_RD : RD_RT;
        w_next     = S_IF;
      end
      S_HALT: begin
        HLT    = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized directed-sequence bench for multicycle_control with an
// instruction-level reference model of the per-microstep control outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = '0;
  logic [5:0] func_code = '0;
  logic       mem_ready = 1'b0;

  logic       PVSWriteEn, jump, branch, WWD, HLT;
  logic       MemRead, MemWrite, RegWrite, MemDest, JumpDest, carry;
  logic [1:0] MemToReg, RegDest, Bcond, ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp;

  typedef struct packed {
    logic       pvs, jmp, br, wwd, hlt;
    logic [1:0] m2r;
    logic       mrd, mwr, rw, md;
    logic [1:0] rd;
    logic       jd;
    logic [1:0] bc, sa, sb;
    logic [3:0] aop;
    logic       cy;
  } out_t;

  typedef enum {P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT} ph_t;

  int         nvec = 0;
  int         nerr = 0;
  int         pvs_cnt = 0;
  logic [3:0] cur_op = '0;
  logic [5:0] cur_fn = '0;
  int         rfn[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28};

  multicycle_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .func_code  (func_code),
    .mem_ready  (mem_ready),
    .PVSWriteEn (PVSWriteEn),
    .jump       (jump),
    .branch     (branch),
    .WWD        (WWD),
    .HLT        (HLT),
    .MemToReg   (MemToReg),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemDest    (MemDest),
    .RegDest    (RegDest),
    .JumpDest   (JumpDest),
    .Bcond      (Bcond),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .carry      (carry)
  );

  always #5 clk = ~clk;

  function automatic out_t observe();
    out_t o;
    o = '{PVSWriteEn, jump, branch, WWD, HLT, MemToReg, MemRead,
          MemWrite, RegWrite, MemDest, RegDest, JumpDest, Bcond,
          ALUSrcA, ALUSrcB, ALUOp, carry};
    return o;
  endfunction

  function automatic bit is_rfn_alu(input logic [5:0] fn);
    return fn <= 6'd7;
  endfunction

  function automatic bit is_legal(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd10) return 1'b1;
    if (op != 4'd15) return 1'b0;
    return is_rfn_alu(fn) || fn == 6'd25 || fn == 6'd26 ||
           fn == 6'd28 || fn == 6'd29;
  endfunction

  // ALU codes: ADD0 SUB1 AND2 ORR3 NOT4 TCP5 SHL6 SHR7 LHI8 PASSA9
  function automatic logic [3:0] alu_of(input logic [3:0] op,
                                        input logic [5:0] fn);
    if (op <= 4'd3) return 4'd1;
    if (op == 4'd5) return 4'd3;
    if (op == 4'd6) return 4'd8;
    if (op == 4'd15) return is_rfn_alu(fn) ? fn[3:0] : 4'd9;
    return 4'd0;
  endfunction

  function automatic out_t model(input ph_t p, input logic [3:0] op,
                                 input logic [5:0] fn, input logic rdy);
    out_t e;
    bit   rt;
    e  = '0;
    rt = (op == 4'd15);
    case (p)
      P_IF: e.mrd = 1'b1;
      P_ID: begin
        e.sa  = 2'd1;
        e.sb  = 2'd2;
        e.aop = 4'd0;
        if (op == 4'd9 || op == 4'd10) begin
          e.jmp = 1'b1;
          e.pvs = 1'b1;
        end
        if (op == 4'd10) begin
          e.rw  = 1'b1;
          e.rd  = 2'd2;
          e.m2r = 2'd2;
        end
        if (!is_legal(op, fn)) e.pvs = 1'b1;
      end
      P_EX: begin
        e.sa  = 2'd0;
        e.sb  = rt ? 2'd0 : 2'd1;
        e.aop = alu_of(op, fn);
        if (op <= 4'd3) begin
          e.br  = 1'b1;
          e.bc  = 2'(op % 4);
          e.pvs = 1'b1;
        end
        if (rt && (fn == 6'd25 || fn == 6'd26)) begin
          e.jmp = 1'b1;
          e.jd  = 1'b1;
          e.pvs = 1'b1;
        end
        if (rt && fn == 6'd26) begin
          e.rw  = 1'b1;
          e.rd  = 2'd2;
          e.m2r = 2'd2;
        end
        if (rt && fn == 6'd28) begin
          e.wwd = 1'b1;
          e.pvs = 1'b1;
        end
      end
      P_MEM: begin
        e.md  = 1'b1;
        e.mrd = (op == 4'd7);
        e.mwr = (op == 4'd8);
        e.pvs = (op == 4'd8) && rdy;
      end
      P_WB: begin
        e.rw  = 1'b1;
        e.pvs = 1'b1;
        e.m2r = (op == 4'd7) ? 2'd1 : 2'd0;
        e.rd  = rt ? 2'd0 : 2'd1;
      end
      P_HALT: e.hlt = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input out_t o, input out_t e);
    logic [$bits(out_t)-1:0] ov, ev;
    ov = o;
    ev = e;
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, ov, ev);
    end
  endtask

  task automatic step(input ph_t p, input logic rdy, input string tag);
    out_t o;
    @(negedge clk);
    opcode    = cur_op;
    func_code = cur_fn;
    mem_ready = rdy;
    #1;
    o = observe();
    if (o.pvs === 1'b1) pvs_cnt++;
    chk($sformatf("%s/%s op=%0d fn=%0d", tag, p.name(), cur_op, cur_fn),
        o, model(p, cur_op, cur_fn, rdy));
  endtask

  task automatic run(input logic [3:0] op, input logic [5:0] fn,
                     input int sif, input int smem, input string tag);
    bit halted;
    halted  = 1'b0;
    cur_op  = op;
    cur_fn  = fn;
    pvs_cnt = 0;
    repeat (sif) step(P_IF, 1'b0, tag);
    step(P_IF, 1'b1, tag);
    step(P_ID, 1'($urandom_range(0, 1)), tag);
    if (!is_legal(op, fn) || op == 4'd9 || op == 4'd10) begin
      halted = 1'b0;
    end else if (op == 4'd15 && fn == 6'd29) begin
      halted = 1'b1;
      repeat (100) step(P_HALT, 1'($urandom_range(0, 1)), tag);
    end else begin
      step(P_EX, 1'($urandom_range(0, 1)), tag);
      if (op == 4'd7 || op == 4'd8) begin
        repeat (smem) step(P_MEM, 1'b0, tag);
        step(P_MEM, 1'b1, tag);
        if (op == 4'd7) step(P_WB, 1'($urandom_range(0, 1)), tag);
      end else if ((op >= 4'd4 && op <= 4'd6) ||
                   (op == 4'd15 && is_rfn_alu(fn))) begin
        step(P_WB, 1'($urandom_range(0, 1)), tag);
      end
    end
    nvec++;
    assert (pvs_cnt === (halted ? 0 : 1)) else begin
      nerr++;
      $error("FAIL %s retire_count observed=%0d expected=%0d",
             tag, pvs_cnt, halted ? 0 : 1);
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [5:0] fn;
    int         sif, smem;

    #2;
    chk("reset", observe(), model(P_IF, 4'd0, 6'd0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    run(4'd15, 6'd0, 0, 0, "add");
    run(4'd7, 6'($urandom_range(0, 63)), 0, 3, "lwd");
    run(4'd1, 6'($urandom_range(0, 63)), 0, 0, "beq");
    run(4'd10, 6'($urandom_range(0, 63)), 0, 0, "jal");
    run(4'd8, 6'($urandom_range(0, 63)), 2, 1, "swd");

    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd15) begin
        if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
        else fn = 6'(rfn[$urandom_range(0, 10)]);
        if (fn == 6'd29) fn = 6'd28;
      end else begin
        fn = 6'($urandom_range(0, 63));
      end
      sif  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      smem = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run(op, fn, sif, smem, "rnd");
    end

    cur_op  = 4'd4;
    cur_fn  = 6'd0;
    pvs_cnt = 0;
    step(P_IF, 1'b1, "rst_mid");
    step(P_ID, 1'b1, "rst_mid");
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_mid_ex", observe(), model(P_IF, cur_op, cur_fn, 1'b0));
    @(negedge clk);
    #1;
    chk("rst_hold", observe(), model(P_IF, cur_op, cur_fn, 1'b0));
    reset_n = 1'b1;

    run(4'd15, 6'd29, 1, 0, "hlt");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
